ram512_arbiter: RTL and testbench



---
 rtl/ram512_arbiter_if.sv | 41 ++++
 rtl/ram512_arbiter.sv | 99 +++++++++
 tb/tb_ram512_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram512_arbiter_if.sv
// Bundles the two requester ports and the ram512 pins shared by the arbiter.
// slave is the arbiter's view; master is the requesters' and RAM's view.
interface ram512_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_in;
  logic              ram_load;
  logic [DATA_W-1:0] ram_out;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_out,
    output ack0, rdata0, ack1, rdata1,
    output ram_address, ram_in, ram_load
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_out,
    input  ack0, rdata0, ack1, rdata1,
    input  ram_address, ram_in, ram_load
  );
endinterface

// File: rtl/ram512_arbiter.sv
// Round-robin arbiter that shares one ram512 between two requesters.
// Each access runs IDLE -> ACCESS -> ACK, one cycle per state.
module ram512_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ram512_arbiter_if.slave  bus,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              win_q, win_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              grant;
  logic              pick;
  logic              in_access;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Under contention the port that lost the previous grant wins, so grants alternate.
  always_comb begin
    grant    = bus.req0 | bus.req1;
    pick     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    state_d  = state_q;
    win_d    = win_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ACCESS;
          win_d   = pick;
          last_d  = pick;
          we_d    = pick ? bus.we1    : bus.we0;
          addr_d  = pick ? bus.addr1  : bus.addr0;
          wdata_d = pick ? bus.wdata1 : bus.wdata0;
        end
      end
      ACCESS: begin
        state_d = ACK;
        if (win_q) rdata1_d = bus.ram_out;
        else       rdata0_d = bus.ram_out;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM pins decode straight from state so reset drops ram_load without a clock.
  always_comb begin
    in_access       = (state_q == ACCESS);
    bus.ram_address = in_access ? addr_q  : '0;
    bus.ram_in      = in_access ? wdata_q : '0;
    bus.ram_load    = in_access & we_q;
    bus.ack0        = (state_q == ACK) & ~win_q;
    bus.ack1        = (state_q == ACK) &  win_q;
    bus.rdata0      = rdata0_q;
    bus.rdata1      = rdata1_q;
    busy            = (state_q != IDLE);
  end

endmodule

// File: tb/tb_ram512_arbiter.sv
// Self-checking bench for ram512_arbiter with a behavioural ram512 and a
// transaction-level reference model of arbitration and memory contents.
module tb_ram512_arbiter;
  localparam int AW = 9;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic mem_clear;
  logic [DW-1:0] mem [512];

  int total = 0;
  int bad   = 0;
  int w;

  logic [DW-1:0] exp_mem [512];
  logic [DW-1:0] exp_rdata [2];
  int            last_win;
  bit            pend [2];
  bit            pwe [2];
  logic [AW-1:0] paddr [2];
  logic [DW-1:0] pdata [2];

  ram512_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram512_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Behavioural ram512: combinational read, write on the rising edge when load is high.
  assign bus.ram_out = mem[bus.ram_address];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 512; i++) mem[i] <= '0;
    end else if (bus.ram_load) begin
      mem[bus.ram_address] <= bus.ram_in;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    bus.req0   = pend[0];
    bus.we0    = pwe[0];
    bus.addr0  = paddr[0];
    bus.wdata0 = pdata[0];
    bus.req1   = pend[1];
    bus.we1    = pwe[1];
    bus.addr1  = paddr[1];
    bus.wdata1 = pdata[1];
  endtask

  task automatic setReq(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[p]  = 1'b1;
    pwe[p]   = we;
    paddr[p] = a;
    pdata[p] = d;
  endtask

  task automatic modelReset();
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    last_win     = 1;
    pend[0]      = 1'b0;
    pend[1]      = 1'b0;
  endtask

  // Called at a falling edge with the DUT idle and requests already driven; returns in the ack cycle.
  task automatic accessCheck(input string tag, output int win);
    logic [DW-1:0] old;
    checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " idle ack0"}, 32'(bus.ack0), 32'd0);
    checkOutput({tag, " idle ack1"}, 32'(bus.ack1), 32'd0);
    checkOutput({tag, " idle load"}, 32'(bus.ram_load), 32'd0);
    if (pend[0] && pend[1]) win = 1 - last_win;
    else                    win = pend[1] ? 1 : 0;
    old = exp_mem[paddr[win]];
    @(negedge clk);
    checkOutput({tag, " acc load"}, 32'(bus.ram_load), 32'(pwe[win]));
    checkOutput({tag, " acc addr"}, 32'(bus.ram_address), 32'(paddr[win]));
    checkOutput({tag, " acc in"}, 32'(bus.ram_in), 32'(pdata[win]));
    checkOutput({tag, " acc busy"}, 32'(busy), 32'd1);
    checkOutput({tag, " acc acks"}, 32'({bus.ack1, bus.ack0}), 32'd0);
    @(negedge clk);
    checkOutput({tag, " ack0"}, 32'(bus.ack0), 32'(win == 0));
    checkOutput({tag, " ack1"}, 32'(bus.ack1), 32'(win == 1));
    checkOutput({tag, " rdata0"}, 32'(bus.rdata0), 32'((win == 0) ? old : exp_rdata[0]));
    checkOutput({tag, " rdata1"}, 32'(bus.rdata1), 32'((win == 1) ? old : exp_rdata[1]));
    checkOutput({tag, " ack load"}, 32'(bus.ram_load), 32'd0);
    checkOutput({tag, " ack busy"}, 32'(busy), 32'd1);
    exp_rdata[win] = old;
    if (pwe[win]) exp_mem[paddr[win]] = pdata[win];
    last_win  = win;
    pend[win] = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_clear = 1'b1;
    for (int i = 0; i < 512; i++) exp_mem[i] = '0;
    for (int p = 0; p < 2; p++) begin
      pwe[p]   = 1'b0;
      paddr[p] = '0;
      pdata[p] = '0;
    end
    modelReset();
    applyStimulus();
    repeat (2) @(negedge clk);
    mem_clear = 1'b0;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset acks", 32'({bus.ack1, bus.ack0}), 32'd0);
    checkOutput("reset rdata0", 32'(bus.rdata0), 32'd0);
    checkOutput("reset rdata1", 32'(bus.rdata1), 32'd0);
    checkOutput("reset addr", 32'(bus.ram_address), 32'd0);
    checkOutput("reset in", 32'(bus.ram_in), 32'd0);
    checkOutput("reset load", 32'(bus.ram_load), 32'd0);
    rst_n = 1'b1;

    // Port 0 writes then reads back, holding req0 across the ack for back-to-back access.
    setReq(0, 1'b1, 9'h1A5, 16'hBEEF);
    applyStimulus();
    accessCheck("wr0", w);
    setReq(0, 1'b0, 9'h1A5, 16'h0000);
    applyStimulus();
    @(negedge clk);
    accessCheck("rd0", w);
    checkOutput("rd0 value", 32'(bus.rdata0), 32'h0000BEEF);

    // Port 1 alone: preload 0x100 then read it; port 0's data must be untouched.
    setReq(1, 1'b1, 9'h100, 16'h1234);
    applyStimulus();
    @(negedge clk);
    accessCheck("pre1", w);
    setReq(1, 1'b0, 9'h100, 16'h0000);
    applyStimulus();
    @(negedge clk);
    accessCheck("iso1", w);
    checkOutput("iso rdata1", 32'(bus.rdata1), 32'h00001234);
    checkOutput("iso rdata0", 32'(bus.rdata0), 32'h0000BEEF);

    // Continuous contention: both ports keep requesting writes.
    setReq(0, 1'b1, 9'h000, 16'hA000);
    setReq(1, 1'b1, 9'h001, 16'hB001);
    applyStimulus();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      accessCheck("cont", w);
      if (k < 3) begin
        if (w == 0) setReq(0, 1'b1, 9'h000, 16'hA000 + 16'(k));
        else        setReq(1, 1'b1, 9'h001, 16'hB001 + 16'(k));
        applyStimulus();
        @(negedge clk);
      end
    end

    // Reset asserted in the middle of a write to address 5.
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    applyStimulus();
    @(negedge clk);
    setReq(0, 1'b1, 9'h005, 16'hFFFF);
    applyStimulus();
    @(negedge clk);
    checkOutput("rstwr load", 32'(bus.ram_load), 32'd1);
    checkOutput("rstwr addr", 32'(bus.ram_address), 32'h5);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstwr async load", 32'(bus.ram_load), 32'd0);
    checkOutput("rstwr async busy", 32'(busy), 32'd0);
    checkOutput("rstwr async acks", 32'({bus.ack1, bus.ack0}), 32'd0);
    checkOutput("rstwr async rdata0", 32'(bus.rdata0), 32'd0);
    checkOutput("rstwr async rdata1", 32'(bus.rdata1), 32'd0);
    checkOutput("rstwr async addr", 32'(bus.ram_address), 32'd0);
    checkOutput("rstwr async in", 32'(bus.ram_in), 32'd0);
    modelReset();
    applyStimulus();
    repeat (2) @(negedge clk);
    checkOutput("rst held load", 32'(bus.ram_load), 32'd0);
    checkOutput("rst held acks", 32'({bus.ack1, bus.ack0}), 32'd0);
    rst_n = 1'b1;

    // First contested grant after reset goes to port 0; address 5 kept its old value.
    setReq(0, 1'b0, 9'h005, 16'h0000);
    setReq(1, 1'b0, 9'h1A5, 16'h0000);
    applyStimulus();
    accessCheck("post rst", w);
    checkOutput("post rst ack0", 32'(bus.ack0), 32'd1);
    checkOutput("post rst rd5", 32'(bus.rdata0), 32'h0000);
    applyStimulus();
    @(negedge clk);
    accessCheck("post rst p1", w);

    // Random traffic; a losing request stays pending with its values frozen.
    for (int n = 0; n < 60; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          setReq(p, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 511)) : AW'($urandom_range(0, 31)),
                 DW'($urandom));
        end
      end
      if (!pend[0] && !pend[1]) setReq(int'($urandom_range(0, 1)), 1'b0, AW'($urandom_range(0, 31)), 16'h0000);
      applyStimulus();
      @(negedge clk);
      accessCheck("rand", w);
    end

    pend[0] = 1'b0;
    pend[1] = 1'b0;
    applyStimulus();
    @(negedge clk);
    checkOutput("final busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
